// File: rtl/rr_resource_arbiter_if.sv
// Handshake bundle between requester front-ends (master) and the round-robin
// arbiter (slave) that owns the shared datapath select/enable.
interface rr_resource_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic             res_ready;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             beat;
  logic [7:0]       beat_cnt;
  logic             preempt;

  modport master (
    output req, last, res_ready,
    input  gnt, gnt_id, busy, beat, beat_cnt, preempt
  );

  modport slave (
    input  req, last, res_ready,
    output gnt, gnt_id, busy, beat, beat_cnt, preempt
  );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting a shared resource for a burst of beats, with
// release on last beat, request withdrawal, or the HOLD_MAX starvation guard.
module rr_resource_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned ID_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_resource_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  logic             busy;
  logic             beat;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             rel_last;
  logic             rel_wd;
  logic             rel_lim;

  assign busy     = (state_q == StGrant);
  assign beat     = busy & bus.req[gnt_id_q] & bus.res_ready;
  assign rel_last = beat & bus.last[gnt_id_q];
  assign rel_wd   = busy & ~bus.req[gnt_id_q];
  assign rel_lim  = beat & (cnt_q == 8'(HOLD_MAX - 1));

  // Scan starting just after the last winner so it becomes lowest priority.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(rr_ptr_q) + off) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StGrant;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          rr_ptr_d    = win;
          cnt_d       = '0;
        end
      end
      StGrant: begin
        if (beat && cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (rel_last || rel_wd || rel_lim) begin
          state_d   = StIdle;
          gnt_d     = '0;
          gnt_id_d  = '0;
          // A last beat that lands on the limit is a normal end, not a preemption.
          preempt_d = rel_lim & ~rel_last;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      rr_ptr_q  <= ID_W'(N_REQ - 1);
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.busy     = busy;
  assign bus.beat     = beat;
  assign bus.beat_cnt = cnt_q;
  assign bus.preempt  = preempt_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed and soak checks for rr_resource_arbiter; dut_a uses HOLD_MAX=16,
// dut_b uses HOLD_MAX=4 for the coincident last/limit corner.
module tb_rr_resource_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_resource_arbiter_if #(.N_REQ(4), .ID_W(2)) bus_a ();
  rr_resource_arbiter_if #(.N_REQ(4), .ID_W(2)) bus_b ();

  rr_resource_arbiter #(.N_REQ(4), .HOLD_MAX(16), .ID_W(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rr_resource_arbiter #(.N_REQ(4), .HOLD_MAX(4), .ID_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic       beat;
    logic [7:0] cnt;
    logic       pre;
  } vec_t;

  vec_t tbl [27];
  logic prev_lim [2];
  logic prev_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] r, input logic [3:0] l, input logic y);
    bus_a.req       = r;
    bus_a.last      = l;
    bus_a.res_ready = y;
  endtask

  task automatic inv(input int d, input logic [3:0] req, input logic [3:0] last,
                     input logic rdy, input logic [3:0] gnt, input logic [1:0] id,
                     input logic busy, input logic beat, input logic [7:0] cnt,
                     input logic pre, input int hold);
    logic exp_beat;
    check($sformatf("inv%0d_onehot", d), 32'($onehot0(gnt)), 32'd1);
    check($sformatf("inv%0d_busy", d), 32'(busy), 32'(|gnt));
    check($sformatf("inv%0d_gnt_id", d), 32'(id), 32'(idx_of(gnt)));
    exp_beat = busy & req[id] & rdy;
    check($sformatf("inv%0d_beat", d), 32'(beat), 32'(exp_beat));
    if (prev_ok) check($sformatf("inv%0d_preempt", d), 32'(pre), 32'(prev_lim[d]));
    prev_lim[d] = exp_beat & (cnt == 8'(hold - 1)) & ~last[id];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_ok = 1'b0;
    prev_lim[0] = 1'b0;
    prev_lim[1] = 1'b0;
    rst_n = 1'b0;
    drive_a(4'b0, 4'b0, 1'b0);
    bus_b.req = 4'b0;
    bus_b.last = 4'b0;
    bus_b.res_ready = 1'b0;

    //          req      last     rdy   gnt      beat  cnt    pre
    tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'd0, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd1, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1101, 1'b1, 4'b0010, 1'b1, 8'd0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'd1, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'd0, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{4'b1111, 4'b0111, 1'b1, 4'b1000, 1'b1, 8'd0, 1'b0};
    tbl[11] = '{4'b1111, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'd1, 1'b0};
    tbl[12] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'd0, 1'b0};
    tbl[14] = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[15] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'd0, 1'b0};
    tbl[16] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'd1, 1'b0};
    tbl[17] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'd2, 1'b0};
    tbl[18] = '{4'b0100, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'd3, 1'b0};
    tbl[19] = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[20] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'd0, 1'b0};
    tbl[21] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 8'd1, 1'b0};
    tbl[22] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'd1, 1'b0};
    tbl[23] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 8'd2, 1'b0};
    tbl[24] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b0};
    tbl[25] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[26] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_gnt", 32'(bus_a.gnt), 32'd0);
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    check("reset_cnt", 32'(bus_a.beat_cnt), 32'd0);
    check("reset_preempt", 32'(bus_a.preempt), 32'd0);
    step();
    rst_n = 1'b1;

    // Round-robin order, withdrawal and backpressure.
    for (int i = 0; i < 27; i++) begin
      if (i > 0) step();
      drive_a(tbl[i].req, tbl[i].last, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), 32'(bus_a.gnt), 32'(tbl[i].gnt));
      check($sformatf("v%0d_busy", i), 32'(bus_a.busy), 32'(|tbl[i].gnt));
      check($sformatf("v%0d_gnt_id", i), 32'(bus_a.gnt_id), 32'(idx_of(tbl[i].gnt)));
      check($sformatf("v%0d_beat", i), 32'(bus_a.beat), 32'(tbl[i].beat));
      check($sformatf("v%0d_preempt", i), 32'(bus_a.preempt), 32'(tbl[i].pre));
      if (tbl[i].gnt != 4'b0)
        check($sformatf("v%0d_cnt", i), 32'(bus_a.beat_cnt), 32'(tbl[i].cnt));
    end

    // Async reset in the middle of a grant.
    step();
    drive_a(4'b1111, 4'b0000, 1'b0);
    @(negedge clk);
    check("pre_rst_idle", 32'(bus_a.gnt), 32'd0);
    step();
    @(negedge clk);
    check("pre_rst_gnt", 32'(bus_a.gnt), 32'b1000);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(bus_a.gnt), 32'd0);
    check("async_rst_busy", 32'(bus_a.busy), 32'd0);
    check("async_rst_preempt", 32'(bus_a.preempt), 32'd0);
    step();
    drive_a(4'b0011, 4'b0000, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(bus_a.gnt), 32'd0);

    // HOLD_MAX=16 preemption between two requesters.
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge clk);
      check($sformatf("hold_gnt%0d", i), 32'(bus_a.gnt), 32'b0001);
      check($sformatf("hold_cnt%0d", i), 32'(bus_a.beat_cnt), 32'(i));
      check($sformatf("hold_beat%0d", i), 32'(bus_a.beat), 32'd1);
      check($sformatf("hold_pre%0d", i), 32'(bus_a.preempt), 32'd0);
    end
    step();
    @(negedge clk);
    check("preempt_idle_gnt", 32'(bus_a.gnt), 32'd0);
    check("preempt_pulse", 32'(bus_a.preempt), 32'd1);
    step();
    @(negedge clk);
    check("preempt_next_gnt", 32'(bus_a.gnt), 32'b0010);
    check("preempt_cleared", 32'(bus_a.preempt), 32'd0);
    step();
    drive_a(4'b0000, 4'b0000, 1'b0);

    // HOLD_MAX=4: last coincident with limit, then pure limit, then regrant.
    bus_b.req = 4'b0001;
    bus_b.res_ready = 1'b1;
    @(negedge clk);
    check("b_idle", 32'(bus_b.gnt), 32'd0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        step();
        bus_b.last = (k == 0 && i == 3) ? 4'b0001 : 4'b0000;
        @(negedge clk);
        check($sformatf("b%0d_gnt%0d", k, i), 32'(bus_b.gnt), 32'b0001);
        check($sformatf("b%0d_cnt%0d", k, i), 32'(bus_b.beat_cnt), 32'(i));
      end
      step();
      bus_b.last = 4'b0000;
      @(negedge clk);
      check($sformatf("b%0d_rel_gnt", k), 32'(bus_b.gnt), 32'd0);
      check($sformatf("b%0d_rel_pre", k), 32'(bus_b.preempt), 32'(k));
    end
    step();
    @(negedge clk);
    check("b_regrant", 32'(bus_b.gnt), 32'b0001);

    // Random soak with invariant checks on both instances.
    for (int c = 0; c < 10000; c++) begin
      step();
      drive_a(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      bus_b.req = 4'($urandom);
      bus_b.last = 4'($urandom);
      bus_b.res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      inv(0, bus_a.req, bus_a.last, bus_a.res_ready, bus_a.gnt, bus_a.gnt_id, bus_a.busy,
          bus_a.beat, bus_a.beat_cnt, bus_a.preempt, 16);
      inv(1, bus_b.req, bus_b.last, bus_b.res_ready, bus_b.gnt, bus_b.gnt_id, bus_b.busy,
          bus_b.beat, bus_b.beat_cnt, bus_b.preempt, 4);
      prev_ok = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
